posit_decode_arbiter: RTL and testbench
=======================================

Name: posit_decode_arbiter

Overview:
- Shares a single posit_decoder instance between two requesters (e.g. the A and B operand paths of a posit arithmetic unit).
- Round-robin arbitration; latches the winner's posit word and drives the decoder's start/posit_num.
- Waits for done, captures the decoded fields and returns them on a shared result bus with a per-requester valid pulse.
- A watchdog aborts a hung decode and reports an error.

Parameters:
- TIMEOUT, 64: maximum cycles in BUSY before abort. Must be ≥2 and ≤ 2^CNT_W.
- CNT_W, 7: width of the watchdog counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- req0  input  1  requester 0 request, level; held until res_valid0
- posit0  input  32  requester 0 posit word, sampled on grant
- req1  input  1  requester 1 request, level; held until res_valid1
- posit1  input  32  requester 1 posit word, sampled on grant
- dec_posit  output  32  posit_num to decoder
- dec_start  output  1  start to decoder
- dec_sign  input  1  decoder sign
- dec_done  input  1  decoder done
- dec_k  input  6  decoder regime k, two's complement
- dec_exp  input  3  decoder exp_value
- dec_mant  input  32  decoder mantissa
- res_valid0  output  1  one-cycle pulse: result belongs to requester 0
- res_valid1  output  1  one-cycle pulse: result belongs to requester 1
- res_sign  output  1  captured sign
- res_k  output  6  captured k
- res_exp  output  3  captured exp
- res_mant  output  32  captured mantissa
- res_err  output  1  qualifies res_valid*: decode timed out, data fields zero
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset state:
  - All outputs 0; FSM = IDLE; watchdog counter = 0.
  - last_gnt = 1, so requester 0 wins the first tie.
  - rst has priority over all other activity.
  - Reset mid-operation: dec_start drops the next cycle and no res_valid is issued.
- All outputs are registered.
- State IDLE:
  - Neither request high: stay in IDLE.
  - Exactly one request high: grant it.
  - Both high: grant the requester that is not last_gnt.
  - On grant: latch that requester's posit into dec_posit, record gnt_id, update last_gnt, go to BUSY.
  - dec_start = 1 in the first BUSY cycle, i.e. the cycle after the request is sampled.
- State BUSY:
  - dec_start held at 1; watchdog increments each cycle.
  - dec_done = 1: capture dec_sign/k/exp/mant into res_*, set res_err = 0, go to RESP.
  - Else, if watchdog = TIMEOUT-1: set res_* = 0, res_err = 1, go to RESP.
  - dec_done wins if it coincides with the timeout cycle.
- State RESP (one cycle):
  - res_valid[gnt_id] = 1; dec_start = 0; watchdog cleared.
  - Next state DRAIN.
  - res_* hold their values until the next RESP.
  - res_err is cleared on the next successful capture.
- State DRAIN:
  - dec_start = 0.
  - Stay until dec_done is sampled 0, then go to IDLE.
  - This guarantees the decoder sees start low and has released done before the next job.
- Requester rule:
  - A requester drops req in the cycle after its res_valid; res_valid is registered and seen at the clock edge.
  - req is not sampled in RESP or DRAIN, so a held req is simply re-arbitrated in IDLE. Fairness still holds via last_gnt.
- dec_posit is stable from grant until the next grant. posit inputs may change freely after the grant cycle.
- Minimum turnaround is IDLE→BUSY→RESP→DRAIN→IDLE = 4 cycles plus decoder latency.
- Decoder-side protocol: start is a level held until done; done may stay high while start is high.

Test Plan:
- Single job:
  - Stimulus: rst for 10 cycles, then req0=1 with posit0=32'h0DCCCCCC; model decoder returns done after 8 cycles.
  - Required: dec_posit=32'h0DCCCCCC and dec_start=1 one cycle after req0; res_valid0 pulses the cycle after dec_done with res_* equal to the decoder outputs; res_valid1 stays 0; busy returns to 0 after DRAIN.
- Tie:
  - Stimulus: req0 and req1 asserted in the same cycle after reset.
  - Required: requester 0 is served first, then requester 1; exactly one res_valid pulse each, in that order.
- Fairness:
  - Stimulus: req0 and req1 held continuously (re-asserted after each result) for 6 jobs.
  - Required: grants strictly alternate 0,1,0,1,0,1.
- Timeout:
  - Stimulus: TIMEOUT=16; decoder model never asserts done.
  - Required: res_valid0 and res_err=1 with res_k=0, res_exp=0 and res_mant=0, 16 cycles after dec_start rose; then the FSM returns to IDLE.
- Drain:
  - Stimulus: decoder model holds done high for 5 cycles after start drops.
  - Required: no new dec_start until dec_done is low; busy stays 1 through DRAIN.
- Reset mid-op:
  - Stimulus: assert rst during BUSY.
  - Required: all outputs 0 on the next edge; no res_valid; after release, req1 is served first only if req0 is absent.

Source files
------------

// File: rtl/posit_decode_arbiter.sv
// Round-robin arbiter sharing one posit decoder between two requesters.
// Latches the winner's word, waits for done (or a watchdog abort) and returns the fields.
module posit_decode_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] posit0,
  input  logic        req1,
  input  logic [31:0] posit1,
  output logic [31:0] dec_posit,
  output logic        dec_start,
  input  logic        dec_sign,
  input  logic        dec_done,
  input  logic [5:0]  dec_k,
  input  logic [2:0]  dec_exp,
  input  logic [31:0] dec_mant,
  output logic        res_valid0,
  output logic        res_valid1,
  output logic        res_sign,
  output logic [5:0]  res_k,
  output logic [2:0]  res_exp,
  output logic [31:0] res_mant,
  output logic        res_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_r;
  logic [CNT_W-1:0] wdog_r;
  logic             last_gnt_r;
  logic             gnt_id_r;
  logic             grant_s;
  logic             grant_id_s;

  // Round-robin pick: on a tie the requester not served last wins
  always_comb begin
    grant_s    = 1'b0;
    grant_id_s = 1'b0;
    if (req0 && req1) begin
      grant_s    = 1'b1;
      grant_id_s = ~last_gnt_r;
    end else if (req0) begin
      grant_s    = 1'b1;
      grant_id_s = 1'b0;
    end else if (req1) begin
      grant_s    = 1'b1;
      grant_id_s = 1'b1;
    end else begin
      grant_s    = 1'b0;
      grant_id_s = 1'b0;
    end
  end

  // Arbitration FSM with registered decoder controls and result bus
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      wdog_r     <= {CNT_W{1'b0}};
      last_gnt_r <= 1'b1;
      gnt_id_r   <= 1'b0;
      dec_posit  <= 32'd0;
      dec_start  <= 1'b0;
      res_valid0 <= 1'b0;
      res_valid1 <= 1'b0;
      res_sign   <= 1'b0;
      res_k      <= 6'd0;
      res_exp    <= 3'd0;
      res_mant   <= 32'd0;
      res_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      res_valid0 <= 1'b0;
      res_valid1 <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            dec_posit  <= grant_id_s ? posit1 : posit0;
            gnt_id_r   <= grant_id_s;
            last_gnt_r <= grant_id_s;
            dec_start  <= 1'b1;
            busy       <= 1'b1;
            wdog_r     <= {CNT_W{1'b0}};
            state_r    <= BUSY;
          end else begin
            state_r    <= IDLE;
          end
        end
        BUSY: begin
          // A late done still wins over the abort on the same cycle
          if (dec_done) begin
            res_sign   <= dec_sign;
            res_k      <= dec_k;
            res_exp    <= dec_exp;
            res_mant   <= dec_mant;
            res_err    <= 1'b0;
            res_valid0 <= ~gnt_id_r;
            res_valid1 <= gnt_id_r;
            dec_start  <= 1'b0;
            state_r    <= RESP;
          end else if (wdog_r == WDOG_LAST) begin
            res_sign   <= 1'b0;
            res_k      <= 6'd0;
            res_exp    <= 3'd0;
            res_mant   <= 32'd0;
            res_err    <= 1'b1;
            res_valid0 <= ~gnt_id_r;
            res_valid1 <= gnt_id_r;
            dec_start  <= 1'b0;
            state_r    <= RESP;
          end else begin
            wdog_r     <= wdog_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RESP: begin
          wdog_r  <= {CNT_W{1'b0}};
          state_r <= DRAIN;
        end
        DRAIN: begin
          if (!dec_done) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          dec_start <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_posit_decode_arbiter.sv
// Scoreboard bench for posit_decode_arbiter with a behavioural decoder model.
module tb_posit_decode_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst, req0, req1;
  logic [31:0] posit0, posit1;
  logic [31:0] dec_posit;
  logic        dec_start;
  logic        dec_sign = 1'b0, dec_done = 1'b0;
  logic [5:0]  dec_k = 6'd0;
  logic [2:0]  dec_exp = 3'd0;
  logic [31:0] dec_mant = 32'd0;
  logic        res_valid0, res_valid1, res_sign, res_err, busy;
  logic [5:0]  res_k;
  logic [2:0]  res_exp;
  logic [31:0] res_mant;

  typedef struct packed {
    logic [1:0]  id;
    logic        err;
    logic        sign;
    logic [5:0]  k;
    logic [2:0]  ex;
    logic [31:0] mant;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, n_v0 = 0, n_v1 = 0;
  int   dec_lat = 8, hold_after = 0, dcnt = 0, hold_left = 0;
  bit   never_done = 1'b0;

  posit_decode_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .posit0(posit0), .req1(req1), .posit1(posit1),
    .dec_posit(dec_posit), .dec_start(dec_start),
    .dec_sign(dec_sign), .dec_done(dec_done), .dec_k(dec_k),
    .dec_exp(dec_exp), .dec_mant(dec_mant),
    .res_valid0(res_valid0), .res_valid1(res_valid1),
    .res_sign(res_sign), .res_k(res_k), .res_exp(res_exp),
    .res_mant(res_mant), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Decoder model: done after dec_lat start cycles, held hold_after cycles past start dropping
  always @(posedge clk) begin
    if (dec_start) begin
      dcnt <= dcnt + 1;
      if (!never_done && dcnt == dec_lat - 1) begin
        dec_done  <= 1'b1;
        dec_sign  <= dec_posit[31];
        dec_k     <= dec_posit[5:0];
        dec_exp   <= dec_posit[8:6];
        dec_mant  <= {dec_posit[30:0], 1'b1};
        hold_left <= hold_after;
      end
    end else begin
      dcnt <= 0;
      if (dec_done && hold_left > 0) hold_left <= hold_left - 1;
      else dec_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (res_valid0) n_v0 <= n_v0 + 1;
    if (res_valid1) n_v1 <= n_v1 + 1;
  end

  function automatic res_t ok_res(input logic [1:0] id, input logic [31:0] p);
    res_t r;
    r.id = id; r.err = 1'b0; r.sign = p[31]; r.k = p[5:0]; r.ex = p[8:6];
    r.mant = {p[30:0], 1'b1};
    return r;
  endfunction

  function automatic res_t err_res(input logic [1:0] id);
    res_t r;
    r = '0; r.id = id; r.err = 1'b1;
    return r;
  endfunction

  // Wait (bounded) for the next result pulse; id 2 = no pulse observed, id 3 = both valids at once
  task automatic collect(output res_t obs, output int cyc);
    bit seen;
    seen = 1'b0; cyc = 0; obs = '0; obs.id = 2'd2;
    while (!seen && cyc < 100) begin
      @(negedge clk); cyc++;
      if (res_valid0 || res_valid1) begin
        seen = 1'b1;
        obs.id = (res_valid0 && res_valid1) ? 2'd3 : (res_valid1 ? 2'd1 : 2'd0);
        obs.err = res_err; obs.sign = res_sign; obs.k = res_k;
        obs.ex = res_exp; obs.mant = res_mant;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b0; posit0 = 32'h1234_5678; posit1 = 32'd0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({dec_posit, dec_start, res_valid0, res_valid1, res_sign, res_k, res_exp, res_mant, res_err, busy} !== 79'd0) begin
      n_bad++; $display("FAIL reset_outputs: got dec_posit=%h start=%b busy=%b err=%b, required all zero", dec_posit, dec_start, busy, res_err);
    end
    rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || dec_start !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_req: got busy=%b start=%b, required 0 0", busy, dec_start);
    end
  endtask

  task automatic test_single_job();
    res_t obs, e;
    int cyc, b1;
    b1 = n_v1;
    req0 = 1'b1; posit0 = 32'h0DCC_CCCC;
    exp_q.push_back(ok_res(2'd0, posit0));
    @(negedge clk);
    n_cmp++;
    if (dec_start !== 1'b1 || dec_posit !== 32'h0DCC_CCCC) begin
      n_bad++; $display("FAIL single_grant: got start=%b posit=%h, required 1 0dcccccc", dec_start, dec_posit);
    end
    posit0 = 32'hFFFF_FFFF;
    collect(obs, cyc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL single_result: got %h, required %h", obs, e); end
    n_cmp++;
    if (cyc !== 9) begin n_bad++; $display("FAIL single_latency: got %0d cycles, required 9", cyc); end
    req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL single_drain_busy: got %b, required 1", busy); end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || n_v1 !== b1) begin
      n_bad++; $display("FAIL single_idle: got busy=%b v1_pulses=%0d, required 0 %0d", busy, n_v1, b1);
    end
  endtask

  task automatic test_tie();
    res_t obs, e;
    int cyc, b0, b1;
    do_reset();
    b0 = n_v0; b1 = n_v1;
    posit0 = 32'h4A5B_6C7D; posit1 = 32'hB1C2_D3E4; req0 = 1'b1; req1 = 1'b1;
    exp_q.push_back(ok_res(2'd0, posit0));
    exp_q.push_back(ok_res(2'd1, posit1));
    for (int j = 0; j < 2; j++) begin
      collect(obs, cyc);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL tie_result%0d: got %h, required %h", j, obs, e); end
      if (obs.id == 2'd0) req0 = 1'b0;
      else if (obs.id == 2'd1) req1 = 1'b0;
      else begin req0 = 1'b0; req1 = 1'b0; end
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (n_v0 - b0 !== 1 || n_v1 - b1 !== 1) begin
      n_bad++; $display("FAIL tie_pulse_count: got %0d/%0d, required 1/1", n_v0 - b0, n_v1 - b1);
    end
  endtask

  task automatic test_fairness();
    res_t obs, e;
    int cyc, s0, s1;
    logic [31:0] p0 [3];
    logic [31:0] p1 [3];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      p0[k] = $urandom(); p1[k] = $urandom();
      exp_q.push_back(ok_res(2'd0, p0[k]));
      exp_q.push_back(ok_res(2'd1, p1[k]));
    end
    s0 = 0; s1 = 0;
    posit0 = p0[0]; posit1 = p1[0]; req0 = 1'b1; req1 = 1'b1;
    for (int j = 0; j < 6; j++) begin
      collect(obs, cyc);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL fair_job%0d: got %h, required %h", j, obs, e); end
      if (obs.id == 2'd0) begin req0 = 1'b0; s0++; end
      else if (obs.id == 2'd1) begin req1 = 1'b0; s1++; end
      else begin req0 = 1'b0; req1 = 1'b0; s0 = 3; s1 = 3; end
      @(negedge clk);
      if (!req0 && s0 < 3) begin posit0 = p0[s0]; req0 = 1'b1; end
      if (!req1 && s1 < 3) begin posit1 = p1[s1]; req1 = 1'b1; end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    res_t obs, e;
    int cyc;
    never_done = 1'b1;
    req0 = 1'b1; posit0 = 32'h7777_1234;
    exp_q.push_back(err_res(2'd0));
    @(negedge clk);
    n_cmp++;
    if (dec_start !== 1'b1) begin n_bad++; $display("FAIL timeout_start: got %b, required 1", dec_start); end
    collect(obs, cyc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL timeout_result: got %h, required %h", obs, e); end
    n_cmp++;
    if (cyc !== TIMEOUT) begin n_bad++; $display("FAIL timeout_latency: got %0d, required %0d", cyc, TIMEOUT); end
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_idle: got busy=%b, required 0", busy); end
    never_done = 1'b0;
  endtask

  task automatic test_drain();
    res_t obs, e;
    int cyc, hi;
    hold_after = 5;
    req0 = 1'b1; posit0 = 32'h2468_ACE1; posit1 = 32'h9753_1ECA;
    exp_q.push_back(ok_res(2'd0, posit0));
    exp_q.push_back(ok_res(2'd1, posit1));
    @(negedge clk);
    req1 = 1'b1;
    collect(obs, cyc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL drain_first: got %h, required %h", obs, e); end
    req0 = 1'b0;
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dec_done) begin
        hi++;
        n_cmp++;
        if (dec_start !== 1'b0 || busy !== 1'b1) begin
          n_bad++; $display("FAIL drain_hold: got start=%b busy=%b while done high, required 0 1", dec_start, busy);
        end
      end else if (dec_start) begin
        break;
      end
    end
    n_cmp++;
    if (hi !== 5) begin n_bad++; $display("FAIL drain_done_cycles: got %0d, required 5", hi); end
    collect(obs, cyc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL drain_second: got %h, required %h", obs, e); end
    req1 = 1'b0;
    hold_after = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    res_t obs, e;
    int cyc, b0, b1;
    do_reset();
    req0 = 1'b1; posit0 = 32'h1357_9BDF;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({dec_posit, dec_start, res_valid0, res_valid1, res_sign, res_k, res_exp, res_mant, res_err, busy} !== 79'd0) begin
      n_bad++; $display("FAIL midop_reset: got posit=%h start=%b busy=%b, required all zero", dec_posit, dec_start, busy);
    end
    req0 = 1'b0;
    b0 = n_v0; b1 = n_v1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (n_v0 !== b0 || n_v1 !== b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midop_no_result: got pulses %0d/%0d busy=%b, required %0d/%0d 0", n_v0, n_v1, busy, b0, b1);
    end
    posit0 = 32'h0F0F_1234; posit1 = 32'hF0F0_4321; req0 = 1'b1; req1 = 1'b1;
    exp_q.push_back(ok_res(2'd0, posit0));
    exp_q.push_back(ok_res(2'd1, posit1));
    for (int j = 0; j < 2; j++) begin
      collect(obs, cyc);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL midop_after%0d: got %h, required %h", j, obs, e); end
      if (obs.id == 2'd0) req0 = 1'b0;
      else if (obs.id == 2'd1) req1 = 1'b0;
      else begin req0 = 1'b0; req1 = 1'b0; end
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_tie();
    test_fairness();
    test_timeout();
    test_drain();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "bench timed out");
  end

endmodule
